// File: rtl/gf256_pkg.sv
// Shared GF(2^8) constants and engine state encoding, reused by the
// exponent engine and the downstream syndrome/Chien stages.
package gf256_pkg;

    localparam logic [7:0] GF_POLY_DEFAULT = 8'h1D;
    localparam logic [7:0] GF_ALPHA        = 8'h02;
    localparam logic [7:0] GF_ONE          = 8'h01;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier: carry-less 8x8 product reduced modulo
// x^8 + POLY, built as a shift-and-add with the reduction folded in per step.
module gf256_mul
    import gf256_pkg::*;
#(
    parameter logic [7:0] POLY = GF_POLY_DEFAULT
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] shifted;

    // Each step adds a*x^i when b[i] is set, then multiplies the running
    // operand by x and reduces immediately so nothing exceeds 8 bits.
    always_comb begin
        p       = 8'h00;
        shifted = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ shifted;
            end
            shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? POLY : 8'h00);
        end
    end

endmodule

// File: rtl/gf256_exp_engine.sv
// Computes ALPHA^e in GF(2^8) by MSB-first square-and-multiply, one exponent
// bit per clock, and hands the result downstream over a valid/ready pair.
module gf256_exp_engine
    import gf256_pkg::*;
#(
    parameter logic [7:0] POLY  = GF_POLY_DEFAULT,
    parameter logic [7:0] ALPHA = GF_ALPHA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] exp_in,
    input  logic       exp_valid,
    output logic       exp_ready,
    output logic [7:0] result,
    output logic [7:0] result_exp,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       busy
);

    logic [1:0] state_q, state_d;
    logic [7:0] eReg_q, eReg_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] result_q, result_d;
    logic [7:0] resultExp_q, resultExp_d;

    logic [7:0] accSquare;
    logic [7:0] accSquareAlpha;
    logic [7:0] accStep;

    gf256_mul #(.POLY(POLY)) u_square (
        .a (acc_q),
        .b (acc_q),
        .p (accSquare)
    );

    gf256_mul #(.POLY(POLY)) u_alpha (
        .a (accSquare),
        .b (ALPHA),
        .p (accSquareAlpha)
    );

    assign accStep = eReg_q[cnt_q] ? accSquareAlpha : accSquare;

    always_comb begin
        state_d     = state_q;
        eReg_d      = eReg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        resultExp_d = resultExp_q;
        case (state_q)
            IDLE: begin
                if (exp_valid) begin
                    eReg_d  = exp_in;
                    acc_d   = GF_ONE;
                    cnt_d   = 3'd7;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = accStep;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    result_d    = accStep;
                    resultExp_d = eReg_q;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // A pending exponent waits for IDLE; only the output transfer happens here.
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            eReg_q      <= 8'h00;
            acc_q       <= GF_ONE;
            cnt_q       <= 3'd7;
            result_q    <= 8'h00;
            resultExp_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            eReg_q      <= eReg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            resultExp_q <= resultExp_d;
        end
    end

    // Handshake flags are pure state decodes so reset drops them asynchronously.
    assign exp_ready    = (state_q == IDLE);
    assign busy         = (state_q == RUN);
    assign result_valid = (state_q == DONE);
    assign result       = result_q;
    assign result_exp   = resultExp_q;

endmodule

// File: tb/tb_gf256_exp_engine.sv
// Directed bench for gf256_exp_engine: latency, known powers of alpha,
// backpressure, mid-run reset and a full down-counter sweep against an antilog table.
module tb_gf256_exp_engine;

    logic       clk;
    logic       rst_n;
    logic [7:0] exp_in;
    logic       exp_valid;
    logic       exp_ready;
    logic [7:0] result;
    logic [7:0] result_exp;
    logic       result_valid;
    logic       result_ready;
    logic       busy;

    int vectorCount = 0;
    int missCount   = 0;

    logic [7:0] antilog [0:255];

    gf256_exp_engine #(.POLY(8'h1D), .ALPHA(8'h02)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exp_in       (exp_in),
        .exp_valid    (exp_valid),
        .exp_ready    (exp_ready),
        .result       (result),
        .result_exp   (result_exp),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectorCount++;
        if (got !== want) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference antilog by repeated multiply-by-x, independent of square-and-multiply.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    endfunction

    // Holds exp_valid until the engine takes it; returns after the acceptance edge.
    task automatic applyStimulus(input logic [7:0] e);
        int waited;
        waited    = 0;
        exp_in    = e;
        exp_valid = 1'b1;
        while (!exp_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!exp_ready) begin
            checkOutput("accept_timeout", 32'(exp_ready), 32'd1);
        end
        step();
        exp_valid = 1'b0;
    endtask

    task automatic waitForResult(output int cycles, output bit readySeen);
        cycles    = 0;
        readySeen = 1'b0;
        do begin
            step();
            cycles++;
            if (exp_ready) readySeen = 1'b1;
        end while (!result_valid && cycles < 40);
        if (!result_valid) begin
            checkOutput("result_timeout", 32'(result_valid), 32'd1);
        end
    endtask

    logic [7:0] seqExp  [7] = '{8'd0, 8'd7, 8'd8, 8'd9, 8'd16, 8'd254, 8'd255};
    logic [7:0] seqWant [7] = '{8'h01, 8'h80, 8'h1D, 8'h3A, 8'h4C, 8'h8E, 8'h01};

    initial begin
        int  cycles;
        bit  readySeen;
        bit  stable;
        bit  seen [0:255];
        int  distinct;
        logic [7:0] downCount;

        antilog[0] = 8'h01;
        for (int i = 1; i < 256; i++) antilog[i] = xtime(antilog[i-1]);

        exp_in       = 8'h00;
        exp_valid    = 1'b0;
        result_ready = 1'b0;
        rst_n        = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_result", 32'(result), 32'h00);
        checkOutput("rst_result_exp", 32'(result_exp), 32'h00);
        checkOutput("rst_result_valid", 32'(result_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_exp_ready", 32'(exp_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("[TB] single exponent latency");
        applyStimulus(8'h01);
        checkOutput("run_busy", 32'(busy), 32'd1);
        checkOutput("run_exp_ready", 32'(exp_ready), 32'd0);
        waitForResult(cycles, readySeen);
        checkOutput("latency", 32'(cycles), 32'd8);
        checkOutput("e01_result", 32'(result), 32'h02);
        checkOutput("e01_result_exp", 32'(result_exp), 32'h01);
        result_ready = 1'b1;
        step();
        checkOutput("xfer_valid_low", 32'(result_valid), 32'd0);
        checkOutput("xfer_result_hold", 32'(result), 32'h02);

        $display("[TB] result_ready while idle");
        step();
        step();
        checkOutput("idle_ready_noeffect", 32'({exp_ready, busy, result_valid}), 32'b100);
        checkOutput("idle_result_hold", 32'(result), 32'h02);

        $display("[TB] back-to-back exponents");
        for (int k = 0; k < 7; k++) begin
            applyStimulus(seqExp[k]);
            waitForResult(cycles, readySeen);
            checkOutput($sformatf("b2b_result_e%0d", seqExp[k]), 32'(result), 32'(seqWant[k]));
            checkOutput($sformatf("b2b_ready_low_e%0d", seqExp[k]), 32'(readySeen), 32'd0);
        end

        $display("[TB] backpressure");
        step();
        result_ready = 1'b0;
        applyStimulus(8'h08);
        waitForResult(cycles, readySeen);
        checkOutput("bp_result", 32'(result), 32'h1D);
        exp_in    = 8'h55;
        exp_valid = 1'b1;
        stable    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (result !== 8'h1D || result_valid !== 1'b1 || exp_ready !== 1'b0 || busy !== 1'b0)
                stable = 1'b0;
        end
        checkOutput("bp_hold", 32'(stable), 32'd1);
        result_ready = 1'b1;
        step();
        checkOutput("bp_xfer_idle", 32'({exp_ready, result_valid, busy}), 32'b100);
        step();
        exp_valid = 1'b0;
        checkOutput("bp_accept_next", 32'(busy), 32'd1);
        waitForResult(cycles, readySeen);
        checkOutput("bp_new_result", 32'(result), 32'(antilog[8'h55]));
        checkOutput("bp_new_result_exp", 32'(result_exp), 32'h55);
        step();

        $display("[TB] reset mid-run");
        applyStimulus(8'h10);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_flags", 32'({result_valid, exp_ready, busy}), 32'b010);
        checkOutput("midrst_result", 32'(result), 32'h00);
        checkOutput("midrst_result_exp", 32'(result_exp), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        applyStimulus(8'h02);
        waitForResult(cycles, readySeen);
        checkOutput("post_rst_result", 32'(result), 32'h04);
        checkOutput("post_rst_result_exp", 32'(result_exp), 32'h02);
        step();

        $display("[TB] down-counter sweep");
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        downCount = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(downCount);
            waitForResult(cycles, readySeen);
            checkOutput($sformatf("sweep_e%0d", downCount), 32'(result), 32'(antilog[downCount]));
            if (downCount != 8'h00) seen[result] = 1'b1;
            downCount = downCount - 8'd1;
        end
        distinct = 0;
        for (int i = 1; i < 256; i++) if (seen[i]) distinct++;
        checkOutput("sweep_distinct_nonzero", 32'(distinct), 32'd255);
        checkOutput("sweep_zero_absent", 32'(seen[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
